// File: rtl/fsm_inspeccion_multicanal_pkg.sv
// Shared types for the multi-station inspection controller: channel states,
// per-channel status codes and the packed result record stored in the FIFO.
package inspeccion_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INSPECT = 3'd1,
    PASS    = 3'd2,
    FAIL    = 3'd3,
    LOCK    = 3'd4
  } insp_state_t;

  localparam logic [1:0] E_IDLE    = 2'b00;
  localparam logic [1:0] E_INSPECT = 2'b01;
  localparam logic [1:0] E_PASS    = 2'b10;
  localparam logic [1:0] E_FAIL    = 2'b11;

  // Wide enough for the largest supported channel count (16).
  localparam int MAX_CH_W = 4;

  typedef struct packed {
    logic [MAX_CH_W-1:0] ch;
    logic                pass;
  } insp_result_t;

  // Status code shown on e for a given channel state; LOCK reuses the fail code.
  function automatic logic [1:0] state_code(input insp_state_t s);
    logic [1:0] code;
    case (s)
      IDLE:    code = E_IDLE;
      INSPECT: code = E_INSPECT;
      PASS:    code = E_PASS;
      FAIL:    code = E_FAIL;
      LOCK:    code = E_FAIL;
      default: code = E_IDLE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/fsm_inspeccion_multicanal_if.sv
// Result drain bus: the controller is the master presenting the FIFO head,
// the consumer is the slave answering with ready.
interface fsm_inspeccion_multicanal_if #(
  parameter int CH_W = 2
) ();
  logic            res_valid;
  logic            res_ready;
  logic [CH_W-1:0] res_ch;
  logic            res_pass;

  modport master (output res_valid, output res_ch, output res_pass, input res_ready);
  modport slave  (input res_valid, input res_ch, input res_pass, output res_ready);
endinterface

// File: rtl/fsm_inspeccion_multicanal_channel.sv
// One inspection station: Moore FSM with inspection timer, consecutive-reject
// counter, pending flag and latched verdict awaiting arbitration.
module insp_channel_fsm
  import inspeccion_pkg::*;
#(
  parameter int INSPECT_CYCLES = 3,
  parameter int REJECT_LIMIT   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       p,
  input  logic       ri,
  input  logic       alarm_clr,
  input  logic       grant,
  output logic [1:0] e,
  output logic       alarm,
  output logic       pending,
  output logic       verdict,
  output logic       lost
);

  localparam int TW = $clog2(INSPECT_CYCLES) + 1;
  localparam int FW = $clog2(REJECT_LIMIT + 1);
  localparam logic [TW-1:0] T_LOAD  = TW'(INSPECT_CYCLES - 1);
  localparam logic [FW-1:0] F_LIMIT = FW'(REJECT_LIMIT);

  insp_state_t   state_r, state_s;
  logic [TW-1:0] timer_r, timer_s;
  logic [FW-1:0] fail_cnt_r, fail_cnt_s;
  logic          pending_r, pending_s;
  logic          verdict_r, verdict_s;
  logic [1:0]    e_r;
  logic          alarm_r;
  logic          entry_s;

  // Next-state, timer, reject counter and verdict bookkeeping.
  always_comb begin
    state_s    = state_r;
    timer_s    = timer_r;
    fail_cnt_s = fail_cnt_r;
    verdict_s  = verdict_r;
    entry_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (p) begin
          state_s = INSPECT;
          timer_s = T_LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      INSPECT: begin
        if (!p) begin
          state_s = IDLE;
        end else if (timer_r == {TW{1'b0}}) begin
          entry_s   = 1'b1;
          verdict_s = ri;
          if (ri) begin
            state_s    = PASS;
            fail_cnt_s = {FW{1'b0}};
          end else begin
            state_s = FAIL;
            if (fail_cnt_r < F_LIMIT) begin
              fail_cnt_s = fail_cnt_r + {{(FW-1){1'b0}}, 1'b1};
            end else begin
              fail_cnt_s = fail_cnt_r;
            end
          end
        end else begin
          timer_s = timer_r - {{(TW-1){1'b0}}, 1'b1};
        end
      end
      PASS, FAIL: begin
        if (!p) begin
          state_s = (fail_cnt_r == F_LIMIT) ? LOCK : IDLE;
        end else begin
          state_s = state_r;
        end
      end
      LOCK: begin
        if (alarm_clr) begin
          state_s    = IDLE;
          fail_cnt_s = {FW{1'b0}};
        end else begin
          state_s = LOCK;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    if (entry_s) begin
      pending_s = 1'b1;
    end else if (grant) begin
      pending_s = 1'b0;
    end else begin
      pending_s = pending_r;
    end
  end

  // A verdict arriving while the previous one is still unclaimed loses the old one.
  assign lost = entry_s & pending_r & ~grant;

  // Channel registers, including the registered status code and alarm.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      timer_r    <= {TW{1'b0}};
      fail_cnt_r <= {FW{1'b0}};
      pending_r  <= 1'b0;
      verdict_r  <= 1'b0;
      e_r        <= E_IDLE;
      alarm_r    <= 1'b0;
    end else begin
      state_r    <= state_s;
      timer_r    <= timer_s;
      fail_cnt_r <= fail_cnt_s;
      pending_r  <= pending_s;
      verdict_r  <= verdict_s;
      e_r        <= state_code(state_s);
      alarm_r    <= (state_s == LOCK);
    end
  end

  assign e       = e_r;
  assign alarm   = alarm_r;
  assign pending = pending_r;
  assign verdict = verdict_r;

endmodule

// File: rtl/fsm_inspeccion_multicanal.sv
// Multi-station inspection controller: per-channel FSMs, round-robin merge of
// finished verdicts into a result FIFO, valid/ready drain, sticky overflow.
module fsm_inspeccion_multicanal
  import inspeccion_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int INSPECT_CYCLES = 3,
  parameter int REJECT_LIMIT   = 3,
  parameter int FIFO_DEPTH     = 4,
  localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int CW            = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_CH-1:0]   p,
  input  logic [NUM_CH-1:0]   ri,
  input  logic [NUM_CH-1:0]   alarm_clr,
  output logic [2*NUM_CH-1:0] e,
  output logic [NUM_CH-1:0]   alarm,
  output logic [CW-1:0]       fifo_count,
  output logic                overflow,
  fsm_inspeccion_multicanal_if.master res
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [NUM_CH-1:0] pending_vec;
  logic [NUM_CH-1:0] verdict_vec;
  logic [NUM_CH-1:0] lost_vec;
  logic [NUM_CH-1:0] grant_vec;

  logic              grant_vld_s;
  logic [CH_W-1:0]   grant_idx_s;
  logic [CH_W-1:0]   ptr_r;
  logic              overflow_r;

  insp_result_t      mem_r [FIFO_DEPTH];
  logic [AW:0]       wr_ptr_r;
  logic [AW:0]       rd_ptr_r;
  logic [AW:0]       count_s;
  logic              full_s;
  logic              push_s;
  logic              pop_s;
  logic              valid_s;
  insp_result_t      head_s;
  insp_result_t      wdata_s;

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_ch
      assign grant_vec[g] = grant_vld_s && (grant_idx_s == CH_W'(g));
      insp_channel_fsm #(
        .INSPECT_CYCLES (INSPECT_CYCLES),
        .REJECT_LIMIT   (REJECT_LIMIT)
      ) u_ch (
        .clk       (clk),
        .reset     (reset),
        .p         (p[g]),
        .ri        (ri[g]),
        .alarm_clr (alarm_clr[g]),
        .grant     (grant_vec[g]),
        .e         (e[2*g +: 2]),
        .alarm     (alarm[g]),
        .pending   (pending_vec[g]),
        .verdict   (verdict_vec[g]),
        .lost      (lost_vec[g])
      );
    end
  endgenerate

  assign count_s = wr_ptr_r - rd_ptr_r;
  assign full_s  = (count_s == (AW+1)'(FIFO_DEPTH));
  assign valid_s = (count_s != {(AW+1){1'b0}});
  assign pop_s   = valid_s & res.res_ready;
  assign push_s  = grant_vld_s;

  // Round-robin search from the pointer; nothing is granted while the FIFO is full.
  always_comb begin
    int              idx;
    logic [CH_W-1:0] cand;
    grant_vld_s = 1'b0;
    grant_idx_s = {CH_W{1'b0}};
    idx         = 0;
    cand        = {CH_W{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(ptr_r) + i;
      if (idx >= NUM_CH) begin
        idx = idx - NUM_CH;
      end else begin
        idx = idx;
      end
      cand = CH_W'(idx);
      if (!full_s && !grant_vld_s && pending_vec[cand]) begin
        grant_vld_s = 1'b1;
        grant_idx_s = cand;
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
  end

  assign wdata_s.ch   = MAX_CH_W'(grant_idx_s);
  assign wdata_s.pass = verdict_vec[grant_idx_s];

  // Arbiter pointer, FIFO pointers and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_r      <= {CH_W{1'b0}};
      wr_ptr_r   <= {(AW+1){1'b0}};
      rd_ptr_r   <= {(AW+1){1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (grant_vld_s) begin
        ptr_r <= (grant_idx_s == CH_W'(NUM_CH - 1)) ? {CH_W{1'b0}}
                                                    : grant_idx_s + {{(CH_W-1){1'b0}}, 1'b1};
      end
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (|lost_vec) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // FIFO storage; contents are only observed through the valid-gated head.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wdata_s;
    end
  end

  assign head_s        = mem_r[rd_ptr_r[AW-1:0]];
  assign res.res_valid = valid_s;
  assign res.res_ch    = valid_s ? CH_W'(head_s.ch) : {CH_W{1'b0}};
  assign res.res_pass  = valid_s ? head_s.pass : 1'b0;
  assign fifo_count    = CW'(count_s);
  assign overflow      = overflow_r;

endmodule

// File: tb/tb_fsm_inspeccion_multicanal.sv
// Directed bench for the inspection controller with hand-computed expectations.
module tb_fsm_inspeccion_multicanal;

  logic       clk;
  logic       reset;
  logic [3:0] p;
  logic [3:0] ri;
  logic [3:0] alarm_clr;
  logic [7:0] e;
  logic [3:0] alarm;
  logic [2:0] fifo_count;
  logic       overflow;

  int errors;
  int checks;

  fsm_inspeccion_multicanal_if #(.CH_W(2)) res_if ();

  fsm_inspeccion_multicanal #(
    .NUM_CH         (4),
    .INSPECT_CYCLES (3),
    .REJECT_LIMIT   (3),
    .FIFO_DEPTH     (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .p          (p),
    .ri         (ri),
    .alarm_clr  (alarm_clr),
    .e          (e),
    .alarm      (alarm),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .res        (res_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Part present through verdict entry (edge INSPECT_CYCLES counted from 0).
  task automatic start_part(input int ch, input logic pass);
    p[ch]  = 1'b1;
    ri[ch] = pass;
    repeat (4) tick();
  endtask

  task automatic end_part(input int ch);
    p[ch]  = 1'b0;
    ri[ch] = 1'b0;
    tick();
  endtask

  task automatic run_part(input int ch, input logic pass);
    start_part(ch, pass);
    end_part(ch);
  endtask

  initial begin
    logic [1:0] exp_ch [5];
    logic       exp_ps [5];
    errors = 0;
    checks = 0;
    reset = 1'b1;
    p = 4'd0;
    ri = 4'd0;
    alarm_clr = 4'd0;
    res_if.res_ready = 1'b0;
    repeat (2) tick();
    check_eq("rst_e", e, 8'h00);
    check_eq("rst_alarm", alarm, 4'h0);
    check_eq("rst_valid", res_if.res_valid, 1'b0);
    check_eq("rst_ch", res_if.res_ch, 2'd0);
    check_eq("rst_pass", res_if.res_pass, 1'b0);
    check_eq("rst_count", fifo_count, 3'd0);
    check_eq("rst_ovf", overflow, 1'b0);
    reset = 1'b0;

    // Pass path on ch0
    res_if.res_ready = 1'b1;
    p[0] = 1'b1;
    ri[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq($sformatf("pass_insp%0d", k), e[1:0], 2'b01);
    end
    tick();
    check_eq("pass_e10", e[1:0], 2'b10);
    check_eq("pass_novalid_e3", res_if.res_valid, 1'b0);
    tick();
    check_eq("pass_valid_e4", res_if.res_valid, 1'b1);
    check_eq("pass_ch", res_if.res_ch, 2'd0);
    check_eq("pass_pass", res_if.res_pass, 1'b1);
    check_eq("pass_count", fifo_count, 3'd1);
    p[0] = 1'b0;
    ri[0] = 1'b0;
    tick();
    check_eq("pass_popped", fifo_count, 3'd0);
    check_eq("pass_idle", e[1:0], 2'b00);

    // Abort on ch2
    p[2] = 1'b1;
    tick();
    check_eq("abort_insp", e[5:4], 2'b01);
    p[2] = 1'b0;
    tick();
    check_eq("abort_idle", e[5:4], 2'b00);
    repeat (4) tick();
    check_eq("abort_count", fifo_count, 3'd0);
    check_eq("abort_valid", res_if.res_valid, 1'b0);
    check_eq("abort_ovf", overflow, 1'b0);

    // Arbitration wrap: ch3 alone, then ch1 and ch3 together
    res_if.res_ready = 1'b0;
    run_part(3, 1'b1);
    p[1] = 1'b1; p[3] = 1'b1;
    ri[1] = 1'b1; ri[3] = 1'b0;
    repeat (4) tick();
    p[1] = 1'b0; p[3] = 1'b0;
    ri[1] = 1'b0; ri[3] = 1'b0;
    tick();
    tick();
    check_eq("arb_count", fifo_count, 3'd3);
    res_if.res_ready = 1'b1;
    check_eq("arb_ch0", res_if.res_ch, 2'd3);
    check_eq("arb_ps0", res_if.res_pass, 1'b1);
    tick();
    check_eq("arb_ch1", res_if.res_ch, 2'd1);
    check_eq("arb_ps1", res_if.res_pass, 1'b1);
    tick();
    check_eq("arb_ch2", res_if.res_ch, 2'd3);
    check_eq("arb_ps2", res_if.res_pass, 1'b0);
    tick();
    check_eq("arb_empty", fifo_count, 3'd0);

    // Lockout on ch2: FAIL, PASS, FAIL, FAIL, FAIL
    run_part(2, 1'b0);
    check_eq("lock_a0", alarm[2], 1'b0);
    run_part(2, 1'b1);
    run_part(2, 1'b0);
    run_part(2, 1'b0);
    check_eq("lock_a2", alarm[2], 1'b0);
    start_part(2, 1'b0);
    check_eq("lock_fail_e", e[5:4], 2'b11);
    check_eq("lock_held_noalarm", alarm[2], 1'b0);
    end_part(2);
    check_eq("lock_alarm", alarm[2], 1'b1);
    check_eq("lock_e", e[5:4], 2'b11);
    tick();
    p[2] = 1'b1;
    ri[2] = 1'b1;
    repeat (5) tick();
    check_eq("lock_nores_cnt", fifo_count, 3'd0);
    check_eq("lock_nores_vld", res_if.res_valid, 1'b0);
    check_eq("lock_still", alarm[2], 1'b1);
    p[2] = 1'b0;
    ri[2] = 1'b0;
    tick();
    alarm_clr[2] = 1'b1;
    tick();
    alarm_clr[2] = 1'b0;
    check_eq("clr_alarm", alarm[2], 1'b0);
    check_eq("clr_e", e[5:4], 2'b00);
    run_part(2, 1'b0);
    check_eq("clr_cnt_reset", alarm[2], 1'b0);
    tick();

    // Backpressure and overflow
    res_if.res_ready = 1'b0;
    run_part(0, 1'b1);
    run_part(1, 1'b0);
    run_part(2, 1'b1);
    run_part(3, 1'b1);
    check_eq("bp_full", fifo_count, 3'd4);
    run_part(0, 1'b0);
    tick();
    check_eq("bp_held_cnt", fifo_count, 3'd4);
    check_eq("bp_head", res_if.res_ch, 2'd0);
    check_eq("bp_no_ovf", overflow, 1'b0);
    start_part(0, 1'b1);
    check_eq("bp_ovf", overflow, 1'b1);
    end_part(0);
    exp_ch[0] = 2'd0; exp_ps[0] = 1'b1;
    exp_ch[1] = 2'd1; exp_ps[1] = 1'b0;
    exp_ch[2] = 2'd2; exp_ps[2] = 1'b1;
    exp_ch[3] = 2'd3; exp_ps[3] = 1'b1;
    exp_ch[4] = 2'd0; exp_ps[4] = 1'b1;
    res_if.res_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check_eq($sformatf("drain_vld%0d", k), res_if.res_valid, 1'b1);
      check_eq($sformatf("drain_ch%0d", k), res_if.res_ch, exp_ch[k]);
      check_eq($sformatf("drain_ps%0d", k), res_if.res_pass, exp_ps[k]);
      tick();
    end
    check_eq("drain_empty", fifo_count, 3'd0);
    check_eq("drain_ovf_sticky", overflow, 1'b1);

    // Reset mid-operation
    run_part(3, 1'b0);
    run_part(3, 1'b0);
    run_part(3, 1'b0);
    check_eq("mid_alarm3", alarm[3], 1'b1);
    tick();
    res_if.res_ready = 1'b0;
    run_part(0, 1'b1);
    run_part(2, 1'b1);
    p[1] = 1'b1;
    ri[1] = 1'b1;
    repeat (2) tick();
    check_eq("mid_count", fifo_count, 3'd2);
    check_eq("mid_insp1", e[3:2], 2'b01);
    reset = 1'b1;
    tick();
    check_eq("mrst_e", e, 8'h00);
    check_eq("mrst_alarm", alarm, 4'h0);
    check_eq("mrst_count", fifo_count, 3'd0);
    check_eq("mrst_valid", res_if.res_valid, 1'b0);
    check_eq("mrst_ch", res_if.res_ch, 2'd0);
    check_eq("mrst_pass", res_if.res_pass, 1'b0);
    check_eq("mrst_ovf", overflow, 1'b0);
    reset = 1'b0;
    p = 4'd0;
    ri = 4'd0;

    // After reset the pointer restarts at 0: ch1 wins over ch3
    p[1] = 1'b1; p[3] = 1'b1;
    ri[1] = 1'b1; ri[3] = 1'b1;
    repeat (4) tick();
    check_eq("post_e1", e[3:2], 2'b10);
    check_eq("post_e3", e[7:6], 2'b10);
    p = 4'd0;
    ri = 4'd0;
    tick();
    tick();
    check_eq("post_count", fifo_count, 3'd2);
    check_eq("post_first", res_if.res_ch, 2'd1);
    res_if.res_ready = 1'b1;
    tick();
    check_eq("post_second", res_if.res_ch, 2'd3);
    tick();
    check_eq("post_empty", fifo_count, 3'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
